psr_stack_unit: RTL and testbench

Parametrised program-status register unit for the core: holds APSR flags, IPSR exception number and EPSR (T, ICI/IT), and advances the IT state per retired instruction. It adds a LIFO shadow stack that saves and restores the full PSR on exception entry and return. The unit sits beside the decode/execute stage. Flag width, exception-number width and nesting depth are parameters.

---
 rtl/psr_stack_unit.sv | 136 +++++++++++++
 tb/tb_psr_stack_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_stack_unit.sv
// psr_stack_unit
//   Program-status register unit: APSR flags, IPSR exception number and
//   EPSR (T, ICI/IT), with IT-state advance per retired instruction and a
//   LIFO shadow stack that saves/restores the whole PSR on exception
//   entry/return.
//
// Parameters
//   FLAG_W      number of APSR flags, MSB = N mapped from xPSR[31] (1..8)
//   EXC_W       IPSR exception-number width (1..9)
//   STACK_DEPTH number of shadow-stack entries (>= 1)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   set_data[31:0]        xPSR-format write data / new exception number on push
//   en_apsr[FLAG_W-1:0]   per-flag write enables
//   en_ipsr, en_epsr      IPSR / EPSR write enables
//   inst_valid            one instruction retires this cycle (IT advance)
//   push, pop             exception entry / return
//   apsr, ipsr, epsr      registered PSR fields
//   in_it_blk, it_last    IT block active / last instruction of IT block
//   it_cond[3:0]          condition of the current IT instruction
//   depth                 occupied stack entries
//   stack_full/empty      stack status decoded from depth
//   stack_err             sticky illegal-stack-operation flag
module psr_stack_unit #(
    parameter int FLAG_W      = 5,
    parameter int EXC_W       = 9,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [31:0]                        set_data,
    input  logic [FLAG_W-1:0]                  en_apsr,
    input  logic                               en_ipsr,
    input  logic                               en_epsr,
    input  logic                               inst_valid,
    input  logic                               push,
    input  logic                               pop,
    output logic [FLAG_W-1:0]                  apsr,
    output logic [EXC_W-1:0]                   ipsr,
    output logic [9:0]                         epsr,
    output logic                               in_it_blk,
    output logic                               it_last,
    output logic [3:0]                         it_cond,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err
);

    localparam int DW    = $clog2(STACK_DEPTH + 1);
    localparam int AW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int ENT_W = FLAG_W + EXC_W + 10;

    logic [ENT_W-1:0] stack_mem [STACK_DEPTH];

    logic [7:0]    it_cur;
    logic [7:0]    it_nxt;
    logic [9:0]    epsr_adv;
    logic          illegal;
    logic          do_pop;
    logic          do_push;
    logic          may_adv;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    // IT state is scattered across EPSR: it = {epsr[6:3], epsr[2:1], epsr[9:8]}
    assign it_cur    = {epsr[6:3], epsr[2:1], epsr[9:8]};
    assign it_cond   = it_cur[7:4];
    assign in_it_blk = (it_cur[3:0] != 4'b0000);
    assign it_last   = (it_cur[3:0] == 4'b1000);

    assign stack_full  = (depth == DW'(STACK_DEPTH));
    assign stack_empty = (depth == '0);

    assign illegal = (push && pop) || (push && stack_full) || (pop && stack_empty);
    assign do_pop  = pop  && !illegal;
    assign do_push = push && !illegal;
    assign may_adv = (en_apsr == '0) && !en_ipsr && !en_epsr && inst_valid;

    // Index truncation is safe: push never happens when full, pop never when empty
    assign push_idx = AW'(depth);
    assign pop_idx  = AW'(depth - DW'(1));

    // End of block (it[2:0]==0) clears the state; otherwise shift the mask
    // and low condition bit while holding the upper condition bits.
    always_comb begin
        it_nxt = '0;
        if (it_cur[2:0] != 3'b000) begin
            it_nxt = {it_cur[7:5], it_cur[3:0], 1'b0};
        end
        epsr_adv = {it_nxt[1:0], epsr[7], it_nxt[7:4], it_nxt[3:2], epsr[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            apsr      <= '0;
            ipsr      <= '0;
            epsr      <= 10'b0010000000;
            depth     <= '0;
            stack_err <= 1'b0;
        end else if (illegal) begin
            stack_err <= 1'b1;
        end else if (do_pop) begin
            {apsr, ipsr, epsr} <= stack_mem[pop_idx];
            depth              <= depth - DW'(1);
        end else if (do_push) begin
            depth <= depth + DW'(1);
            ipsr  <= set_data[EXC_W-1:0];
            // Clear IT bits, keep T (bit 7) and a (bit 0)
            epsr  <= {2'b00, epsr[7], 6'b000000, epsr[0]};
        end else begin
            for (int unsigned i = 0; i < FLAG_W; i++) begin
                if (en_apsr[i]) begin
                    apsr[i] <= set_data[32 - FLAG_W + i];
                end
            end
            if (en_ipsr) begin
                ipsr <= set_data[EXC_W-1:0];
            end
            if (en_epsr) begin
                epsr <= {set_data[26:24], set_data[15:9]};
            end else if (may_adv) begin
                epsr <= epsr_adv;
            end
        end
    end

    // Stack storage has no reset; depth alone marks valid entries
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            stack_mem[push_idx] <= {apsr, ipsr, epsr};
        end
    end

endmodule

// File: tb/tb_psr_stack_unit.sv
module tb_psr_stack_unit;

    localparam int FLAG_W      = 5;
    localparam int EXC_W       = 9;
    localparam int STACK_DEPTH = 4;
    localparam int DW          = $clog2(STACK_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       set_data;
    logic [FLAG_W-1:0] en_apsr;
    logic              en_ipsr, en_epsr, inst_valid, push, pop;
    logic [FLAG_W-1:0] apsr;
    logic [EXC_W-1:0]  ipsr;
    logic [9:0]        epsr;
    logic              in_it_blk, it_last;
    logic [3:0]        it_cond;
    logic [DW-1:0]     depth;
    logic              stack_full, stack_empty, stack_err;

    psr_stack_unit #(
        .FLAG_W     (FLAG_W),
        .EXC_W      (EXC_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .set_data   (set_data),
        .en_apsr    (en_apsr),
        .en_ipsr    (en_ipsr),
        .en_epsr    (en_epsr),
        .inst_valid (inst_valid),
        .push       (push),
        .pop        (pop),
        .apsr       (apsr),
        .ipsr       (ipsr),
        .epsr       (epsr),
        .in_it_blk  (in_it_blk),
        .it_last    (it_last),
        .it_cond    (it_cond),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    // Reference model: PSR kept as named fields, stack as a queue
    typedef struct {
        bit [7:0]    fl;   // fl[0] = N, fl[1] = Z, ... (flag k from xPSR[31-k])
        int unsigned exc;
        bit [7:0]    it;
        bit          t;
        bit          a;
    } psr_t;

    typedef struct {
        logic [FLAG_W-1:0] apsr;
        logic [EXC_W-1:0]  ipsr;
        logic [9:0]        epsr;
        logic              in_it_blk, it_last;
        logic [3:0]        it_cond;
        logic [DW-1:0]     depth;
        logic              full, empty, err;
    } exp_t;

    psr_t        m;
    psr_t        stk[$];
    bit          m_err;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic model_reset();
        m.fl = '0; m.exc = 0; m.it = '0; m.t = 1'b1; m.a = 1'b0;
        stk.delete();
        m_err = 1'b0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < FLAG_W; k++) e.apsr[FLAG_W-1-k] = m.fl[k];
        e.ipsr      = EXC_W'(m.exc);
        e.epsr      = {m.it[1:0], m.t, m.it[7:4], m.it[3:2], m.a};
        e.in_it_blk = (m.it % 16) != 0;
        e.it_last   = (m.it % 16) == 8;
        e.it_cond   = 4'(m.it / 16);
        e.depth     = DW'(stk.size());
        e.full      = stk.size() == STACK_DEPTH;
        e.empty     = stk.size() == 0;
        e.err       = m_err;
        return e;
    endfunction

    // Build set_data that writes the given IT/T/a through en_epsr
    function automatic logic [31:0] mk_epsr(input bit [7:0] it, input bit t, input bit a);
        logic [31:0] d;
        d        = '0;
        d[26:25] = it[1:0];
        d[24]    = t;
        d[15:10] = it[7:2];
        d[9]     = a;
        return d;
    endfunction

    task automatic model_step(input bit r, input bit pu, input bit po, input bit [FLAG_W-1:0] ea,
                              input bit ei, input bit ee, input bit iv, input bit [31:0] sd);
        if (r) begin
            model_reset();
        end else if ((pu && po) || (pu && stk.size() == STACK_DEPTH) || (po && stk.size() == 0)) begin
            m_err = 1'b1;
        end else if (po) begin
            m = stk.pop_back();
        end else if (pu) begin
            stk.push_back(m);
            m.exc = sd % (1 << EXC_W);
            m.it  = 0;
        end else begin
            for (int k = 0; k < FLAG_W; k++)
                if (ea[FLAG_W-1-k]) m.fl[k] = sd[31-k];
            if (ei) m.exc = sd % (1 << EXC_W);
            if (ee) begin
                m.t  = sd[24];
                m.a  = sd[9];
                m.it = {sd[15:10], sd[26:25]};
            end else if (ea == 0 && !ei && iv) begin
                if (m.it % 8 == 0) m.it = 0;
                else               m.it = (m.it & 8'hE0) | ((m.it << 1) & 8'h1F);
            end
        end
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit [FLAG_W-1:0] ea,
                        input bit ei, input bit ee, input bit iv, input bit [31:0] sd);
        @(negedge clk);
        rst = r; push = pu; pop = po; en_apsr = ea;
        en_ipsr = ei; en_epsr = ee; inst_valid = iv; set_data = sd;
        model_step(r, pu, po, ea, ei, ee, iv, sd);
        exp_q.push_back(model_out());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the registered outputs are a response; compare to the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("apsr",        32'(apsr),        32'(e.apsr));
                chk("ipsr",        32'(ipsr),        32'(e.ipsr));
                chk("epsr",        32'(epsr),        32'(e.epsr));
                chk("in_it_blk",   32'(in_it_blk),   32'(e.in_it_blk));
                chk("it_last",     32'(it_last),     32'(e.it_last));
                chk("it_cond",     32'(it_cond),     32'(e.it_cond));
                chk("depth",       32'(depth),       32'(e.depth));
                chk("stack_full",  32'(stack_full),  32'(e.full));
                chk("stack_empty", 32'(stack_empty), 32'(e.empty));
                chk("stack_err",   32'(stack_err),   32'(e.err));
            end
        end
    end

    initial begin
        int unsigned r;
        rst = 1'b1; push = 0; pop = 0; en_apsr = '0; en_ipsr = 0; en_epsr = 0;
        inst_valid = 0; set_data = '0;
        model_reset();

        step(1, 0, 0, '0, 0, 0, 0, 32'h0);
        step(1, 0, 0, '0, 0, 0, 0, 32'h0);

        // Flag writes
        step(0, 0, 0, 5'b11111, 0, 0, 0, 32'hA000_0000);
        step(0, 0, 0, 5'b00100, 0, 0, 0, 32'h0);

        // IT sequences
        step(0, 0, 0, '0, 0, 1, 0, mk_epsr(8'b0000_1000, 1, 0));
        step(0, 0, 0, '0, 0, 0, 1, 32'h0);
        step(0, 0, 0, '0, 0, 1, 0, mk_epsr(8'b0000_0100, 1, 0));
        step(0, 0, 0, '0, 0, 0, 1, 32'h0);
        step(0, 0, 0, '0, 0, 1, 0, mk_epsr(8'b0001_0010, 1, 1));
        repeat (4) step(0, 0, 0, '0, 0, 0, 1, 32'h0);
        step(0, 0, 0, '0, 0, 1, 0, mk_epsr(8'b1010_0110, 1, 0));
        step(0, 0, 0, '0, 0, 1, 1, mk_epsr(8'b1010_0110, 1, 0));
        step(0, 0, 0, '0, 1, 0, 1, 32'h0000_0042);

        // Nested exceptions and restore
        step(0, 1, 0, '0, 0, 0, 0, 32'd3);
        step(0, 0, 0, '0, 0, 0, 0, 32'h0);
        step(0, 1, 0, '0, 0, 0, 0, 32'd11);
        step(0, 1, 0, '0, 0, 0, 0, 32'd15);
        repeat (3) step(0, 0, 1, '0, 0, 0, 0, 32'h0);

        // Overflow, underflow, conflicts
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0, 0, 0, 0, 32'(20 + i));
        step(0, 1, 1, '0, 0, 0, 0, 32'h0);
        repeat (4) step(0, 0, 1, '0, 0, 0, 0, 32'h0);
        step(0, 0, 1, '0, 0, 0, 0, 32'h0);
        step(0, 1, 0, 5'b10000, 1, 1, 1, 32'hFFFF_FFFF);
        step(0, 0, 1, '0, 0, 0, 0, 32'h0);

        // Mid-operation reset with IT active
        step(1, 0, 0, '0, 0, 0, 0, 32'h0);
        step(0, 1, 0, '0, 0, 0, 0, 32'd5);
        step(0, 1, 0, '0, 0, 0, 0, 32'd6);
        step(0, 0, 0, '0, 0, 1, 0, mk_epsr(8'b0110_1100, 1, 0));
        step(1, 0, 0, '0, 0, 0, 0, 32'h0);
        step(0, 0, 1, '0, 0, 0, 0, 32'h0);
        step(1, 0, 0, '0, 0, 0, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit pu, po, rr, ei, ee, iv;
            bit [FLAG_W-1:0] ea;
            r  = $urandom_range(0, 99);
            rr = (r < 2);
            pu = (r >= 2 && r < 22) || (r >= 95);
            po = (r >= 22 && r < 42) || (r >= 97);
            ea = ($urandom_range(0, 3) == 0) ? FLAG_W'($urandom) : '0;
            ei = ($urandom_range(0, 5) == 0);
            ee = ($urandom_range(0, 4) == 0);
            iv = ($urandom_range(0, 3) != 0);
            step(rr, pu, po, ea, ei, ee, iv, $urandom);
        end

        @(negedge clk);
        push = 0; pop = 0; en_apsr = '0; en_ipsr = 0; en_epsr = 0; inst_valid = 0; rst = 0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
